// File: rtl/uart_pkg.sv
// uart_pkg: shared types, defaults and parity helper for the UART receiver.
// Contents:
//   UART_OVERSAMPLE / UART_DATA_BITS  default parameter values
//   uart_rx_state_t                   receiver FSM state encoding
//   parity()                          expected parity bit for a data word
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DELIVER,
        BREAK
    } uart_rx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity(input logic [8:0] data, input logic odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop synchroniser and 3-sample mid-bit majority vote.
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   rx           asynchronous serial line
//   os_tick      oversampling tick
//   sample_cnt   current tick count within the bit
//   rx_s         synchronised line
//   vote         majority of samples at MID-1, MID and the live MID+1 sample
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          os_tick,
    input  logic [$clog2(OVERSAMPLE)-1:0] sample_cnt,
    output logic                          rx_s,
    output logic                          vote
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_M = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID   = CW'(OVERSAMPLE / 2);

    logic s1, s2, a, b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            a  <= 1'b1;
            b  <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            if (os_tick && sample_cnt == MID_M) a <= s2;
            if (os_tick && sample_cnt == MID)   b <= s2;
        end
    end

    assign rx_s = s2;
    // The third sample is taken live, so the vote is final on the MID+1 tick.
    assign vote = (a & b) | (a & s2) | (b & s2);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with valid/ready output and error flags.
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   os_tick       one-clk pulse at OVERSAMPLE x baud
//   rx            asynchronous serial line, idle high
//   rx_data       received word, stable while rx_valid is high
//   rx_valid      word available, held until accepted
//   rx_ready      consumer accept
//   frame_err     pulse: stop bit sampled low
//   parity_err    pulse: parity mismatch
//   overrun       pulse: good frame dropped because the holding register was full
//   busy          FSM not in IDLE
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] VOTE_AT = CW'(OVERSAMPLE / 2 + 1);

    uart_rx_state_t       state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 rx_s, vote;
    logic                 vote_tick, end_tick;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .os_tick    (os_tick),
        .sample_cnt (cnt),
        .rx_s       (rx_s),
        .vote       (vote)
    );

    assign vote_tick = os_tick && cnt == VOTE_AT;
    assign end_tick  = os_tick && cnt == LAST;
    assign busy      = state != IDLE;

    // Later assignments to cnt/rx_valid in the case arms override the defaults above them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (os_tick) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (vote_tick && vote) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (end_tick) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                    end
                end
                DATA: begin
                    if (vote_tick) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (end_tick && bit_cnt == BW'(DATA_BITS)) begin
                        state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                PARITY: begin
                    if (vote_tick) perr <= vote != parity(9'(shreg), PARITY_ODD != 0);
                    if (end_tick) begin
                        state <= STOP;
                        cnt   <= '0;
                    end
                end
                STOP: begin
                    // The final stop bit hands over at its mid-point so the next start edge is not missed.
                    if (vote_tick) begin
                        if (!vote) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                            cnt       <= '0;
                        end else if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            state <= DELIVER;
                            cnt   <= '0;
                        end
                    end else if (end_tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                    cnt   <= '0;
                    if (perr) begin
                        parity_err <= 1'b1;
                    end else if (rx_valid && !rx_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench; dut_a is 8N1, dut_b is 8E1.
module tb_uart_rx_os;

    logic       clk = 1'b0, rst = 1'b0, os_tick = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b, fe_a_o, fe_b_o, pe_a_o, pe_b_o, ov_a_o, ov_b_o, busy_a, busy_b;
    int         div = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div     <= (div == 3) ? 0 : div + 1;
        os_tick <= (div == 3);
    end

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .frame_err(fe_a_o), .parity_err(pe_a_o), .overrun(ov_a_o), .busy(busy_a));

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .frame_err(fe_b_o), .parity_err(pe_b_o), .overrun(ov_b_o), .busy(busy_b));

    int         vcyc_a = 0, acc_a = 0, fe_a = 0, pe_a = 0, ov_a = 0;
    int         acc_b = 0, fe_b = 0, pe_b = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    int         s_vcyc, s_acc_a, s_fe_a, s_pe_a, s_ov_a, s_acc_b, s_fe_b, s_pe_b;

    always @(posedge clk) begin
        if (val_a) vcyc_a <= vcyc_a + 1;
        if (val_a && rdy_a) begin
            acc_a  <= acc_a + 1;
            last_a <= data_a;
        end
        if (val_b && rdy_b) begin
            acc_b  <= acc_b + 1;
            last_b <= data_b;
        end
        if (fe_a_o) fe_a <= fe_a + 1;
        if (pe_a_o) pe_a <= pe_a + 1;
        if (ov_a_o) ov_a <= ov_a + 1;
        if (fe_b_o) fe_b <= fe_b + 1;
        if (pe_b_o) pe_b <= pe_b + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic snap();
        s_vcyc  = vcyc_a;
        s_acc_a = acc_a;
        s_fe_a  = fe_a;
        s_pe_a  = pe_a;
        s_ov_a  = ov_a;
        s_acc_b = acc_b;
        s_fe_b  = fe_b;
        s_pe_b  = pe_b;
    endtask

    // Drive one line to v for a number of os_tick periods (4 clk each).
    task automatic hold(input bit b, input logic v, input int ticks);
        @(negedge clk);
        if (b) rx_b = v;
        else rx_a = v;
        repeat (ticks * 4 - 1) @(negedge clk);
    endtask

    task automatic send(input bit b, input logic [7:0] d, input bit with_par, input logic par, input logic stop);
        hold(b, 1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b, d[i], 16);
        if (with_par) hold(b, par, 16);
        hold(b, stop, 16);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_valid", val_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_data", data_a, 8'h00);
        check("rst_flags", {fe_a_o, pe_a_o, ov_a_o}, 0);
        rst = 1'b1;
        hold(0, 1'b1, 8);

        snap();
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        hold(0, 1'b1, 16);
        check("a5_accepts", acc_a - s_acc_a, 1);
        check("a5_data", last_a, 8'hA5);
        check("a5_valid_cycles", vcyc_a - s_vcyc, 1);
        check("a5_errs", (fe_a - s_fe_a) + (pe_a - s_pe_a) + (ov_a - s_ov_a), 0);
        check("a5_idle", busy_a, 0);

        snap();
        hold(0, 1'b0, 3);
        check("glitch_busy", busy_a, 1);
        hold(0, 1'b1, 32);
        check("glitch_idle", busy_a, 0);
        check("glitch_accepts", acc_a - s_acc_a, 0);
        check("glitch_errs", (fe_a - s_fe_a) + (pe_a - s_pe_a) + (ov_a - s_ov_a), 0);

        snap();
        send(0, 8'h3C, 0, 1'b0, 1'b0);
        hold(0, 1'b0, 40);
        check("fe_count", fe_a - s_fe_a, 1);
        check("fe_break_busy", busy_a, 1);
        check("fe_no_valid", vcyc_a - s_vcyc, 0);
        hold(0, 1'b1, 16);
        check("fe_released", busy_a, 0);
        check("fe_count_after", fe_a - s_fe_a, 1);
        check("fe_other_errs", (pe_a - s_pe_a) + (ov_a - s_ov_a), 0);

        snap();
        send(1, 8'h07, 1, 1'b0, 1'b1);
        hold(1, 1'b1, 16);
        check("par_bad_pe", pe_b - s_pe_b, 1);
        check("par_bad_accepts", acc_b - s_acc_b, 0);
        send(1, 8'h07, 1, 1'b1, 1'b1);
        hold(1, 1'b1, 16);
        check("par_good_accepts", acc_b - s_acc_b, 1);
        check("par_good_data", last_b, 8'h07);
        check("par_good_pe", pe_b - s_pe_b, 1);
        check("par_fe", fe_b - s_fe_b, 0);

        rdy_a = 1'b0;
        snap();
        send(0, 8'h11, 0, 1'b0, 1'b1);
        hold(0, 1'b1, 16);
        send(0, 8'h22, 0, 1'b0, 1'b1);
        hold(0, 1'b1, 16);
        check("ov_valid", val_a, 1);
        check("ov_data", data_a, 8'h11);
        check("ov_count", ov_a - s_ov_a, 1);
        check("ov_other_errs", (fe_a - s_fe_a) + (pe_a - s_pe_a), 0);
        rdy_a = 1'b1;
        repeat (2) @(negedge clk);
        check("ov_cleared", val_a, 0);
        check("ov_accept_data", last_a, 8'h11);
        check("ov_accepts", acc_a - s_acc_a, 1);

        snap();
        hold(0, 1'b0, 16);
        hold(0, 1'b1, 72);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_valid", val_a, 0);
        rst = 1'b1;
        hold(0, 1'b1, 32);
        send(0, 8'h5A, 0, 1'b0, 1'b1);
        hold(0, 1'b1, 16);
        check("rst_5a_data", last_a, 8'h5A);
        check("rst_5a_accepts", acc_a - s_acc_a, 1);
        check("rst_5a_errs", (fe_a - s_fe_a) + (pe_a - s_pe_a) + (ov_a - s_ov_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
